clock_enable_monitor: RTL

Receive-side checker for a divided clock-enable strobe, such as the output of a clock-enable divider. It counts source clock-enable pulses between consecutive divided strobes and reports each measured period. It flags periods outside a tolerance window and declares lock after a run of good periods. It sits beside any divided-enable consumer (SPI/UART bit-rate enables, LED refresh ticks) as a runtime health monitor and as a verification aid.

---
 rtl/clock_enable_monitor.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_enable_monitor.sv
// -----------------------------------------------------------------------------
// clock_enable_monitor
//
// Receive-side health monitor for a divided clock-enable strobe. It counts
// source enables (i_ce_mhz) between consecutive divided strobes (i_ce_div),
// reports every measured period, flags periods outside the tolerance window
// (including overruns that never see a closing strobe in time) and declares
// lock after par_lock_count consecutive good periods.
//
// Ports:
//   i_clk_mhz      in   1   system clock, rising edge
//   i_rst_mhz      in   1   synchronous reset, active low
//   i_ce_mhz       in   1   source clock enable being divided
//   i_ce_div       in   1   divided strobe under test (single-cycle pulses)
//   o_locked       out  1   monitor is in lock
//   o_period       out  W   last measured period in i_ce_mhz counts
//   o_period_valid out  1   one-cycle pulse, o_period was updated
//   o_err_pulse    out  1   one-cycle pulse per detected error
//   o_err_count    out  8   saturating error total
//
// Build option: define CE_MONITOR_ERR_COUNT_EN to build the saturating
// o_err_count register; otherwise o_err_count is tied to zero.
// -----------------------------------------------------------------------------
module clock_enable_monitor #(
    parameter int par_ce_divisor = 1000,
    parameter int par_tolerance  = 0,
    parameter int par_lock_count = 4,
    parameter int par_cnt_width  = 16
) (
    input  logic                     i_clk_mhz,
    input  logic                     i_rst_mhz,
    input  logic                     i_ce_mhz,
    input  logic                     i_ce_div,
    output logic                     o_locked,
    output logic [par_cnt_width-1:0] o_period,
    output logic                     o_period_valid,
    output logic                     o_err_pulse,
    output logic [7:0]               o_err_count
);

    localparam int LP_RUN_W = $clog2(par_lock_count + 1);

    localparam logic [par_cnt_width-1:0] LP_LO  = par_cnt_width'(par_ce_divisor - par_tolerance);
    localparam logic [par_cnt_width-1:0] LP_HI  = par_cnt_width'(par_ce_divisor + par_tolerance);
    localparam logic [par_cnt_width-1:0] LP_MAX = {par_cnt_width{1'b1}};
    localparam logic [par_cnt_width-1:0] LP_ONE = par_cnt_width'(1);
    localparam logic [LP_RUN_W-1:0]      LP_RUN_LOCK = LP_RUN_W'(par_lock_count);
    localparam logic [LP_RUN_W-1:0]      LP_RUN_ONE  = LP_RUN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [par_cnt_width-1:0]   cnt_q, cnt_d;
    logic [LP_RUN_W-1:0]        run_q, run_d;
    logic                       ovr_q, ovr_d;
    logic                       good_s;
    logic                       eval_s;
    logic                       ovr_hit_s;

    logic                       locked_q, locked_d;
    logic [par_cnt_width-1:0]   period_q, period_d;
    logic                       period_valid_q, period_valid_d;
    logic                       err_pulse_q, err_pulse_d;

    // State, enable counter, good-run counter and overrun flag registers.
    always_ff @(posedge i_clk_mhz) begin
        if (!i_rst_mhz) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: period counting, period evaluation and overrun detection.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        ovr_d     = ovr_q;
        ovr_hit_s = 1'b0;
        // cnt_q holds the enables seen since the previous strobe, so it is the
        // period being closed when a strobe arrives.
        good_s    = (cnt_q >= LP_LO) && (cnt_q <= LP_HI);
        eval_s    = i_ce_div && (state_q != ST_IDLE);

        // An enable coincident with the strobe belongs to the new period.
        if (i_ce_div) begin
            cnt_d = {{(par_cnt_width-1){1'b0}}, i_ce_mhz};
        end else if (i_ce_mhz && (cnt_q != LP_MAX)) begin
            cnt_d = cnt_q + LP_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_ce_div) begin
                    state_d = ST_ACQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQ, ST_LOCK: begin
                if (i_ce_div) begin
                    ovr_d = 1'b0;
                    if (good_s) begin
                        if (state_q == ST_ACQ) begin
                            run_d = run_q + LP_RUN_ONE;
                            if (run_q == (LP_RUN_LOCK - LP_RUN_ONE)) begin
                                state_d = ST_LOCK;
                            end else begin
                                state_d = ST_ACQ;
                            end
                        end else begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = ST_ACQ;
                    end
                end else if (i_ce_mhz && (cnt_q == LP_HI) && !ovr_q) begin
                    // Counter steps past the upper tolerance bound: overrun.
                    ovr_hit_s = 1'b1;
                    ovr_d     = 1'b1;
                    run_d     = '0;
                    state_d   = ST_ACQ;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
                ovr_d   = 1'b0;
            end
        endcase
    end

    // Output next values; an overrun period closes without a second error.
    always_comb begin
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_pulse_d    = 1'b0;
        if (eval_s) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            err_pulse_d    = !good_s && !ovr_q;
        end else if (ovr_hit_s) begin
            err_pulse_d = 1'b1;
        end else begin
            err_pulse_d = 1'b0;
        end
        locked_d = (state_d == ST_LOCK);
    end

    // Registered outputs.
    always_ff @(posedge i_clk_mhz) begin
        if (!i_rst_mhz) begin
            locked_q       <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_pulse_q    <= 1'b0;
        end else begin
            locked_q       <= locked_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            err_pulse_q    <= err_pulse_d;
        end
    end

    assign o_locked       = locked_q;
    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_err_pulse    = err_pulse_q;

`ifdef CE_MONITOR_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating error total, advanced together with the error pulse.
    always_comb begin
        if (err_pulse_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error total register.
    always_ff @(posedge i_clk_mhz) begin
        if (!i_rst_mhz) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign o_err_count = err_count_q;
`else
    assign o_err_count = 8'd0;
`endif

endmodule
